// File: rtl/accel_uart_rx.sv
// UART1 receiver: 2-flop synchroniser, 8N1 deserialiser and show-ahead RX FIFO.
// Define ACCEL_UART_RX_PARITY_EN to add a parity bit (8E1/8O1), i_parity_odd and o_err_parity.
module accel_uart_rx #(
   parameter int log2_fifosz = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [15:0]            i_scaler,
   input  logic [log2_fifosz:0]   i_irq_thresh,
   input  logic                   i_err_clr,
   input  logic                   i_rx,
   output logic [7:0]             o_rdata,
   output logic                   o_rvalid,
   input  logic                   i_rready,
   output logic [log2_fifosz:0]   o_level,
   output logic                   o_full,
   output logic                   o_err_frame,
   output logic                   o_err_overflow,
   output logic                   o_irq
`ifdef ACCEL_UART_RX_PARITY_EN
   ,
   input  logic                   i_parity_odd,
   output logic                   o_err_parity
`endif
);

   localparam int D = 1 << log2_fifosz;
   localparam logic [log2_fifosz:0] DEPTH = {1'b1, {log2_fifosz{1'b0}}};

   typedef enum logic [2:0] {
      IDLE, START, DATA, STOP
`ifdef ACCEL_UART_RX_PARITY_EN
      , PARITY
`endif
   } state_t;

   state_t      state, state_n;
   logic [15:0] cnt, cnt_n;
   logic [2:0]  bitidx, bitidx_n;
   logic [7:0]  shreg, shreg_n;
   logic        rx_meta, rx_s, rx_prev;
   logic        sample, push, frame_set, par_set;

   logic [7:0]             mem [D];
   logic [log2_fifosz-1:0] wr_ptr, rd_ptr;
   logic [log2_fifosz:0]   level;
   logic                   pop, push_ok, ovf_set;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= i_rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state  <= IDLE;
         cnt    <= '0;
         bitidx <= '0;
         shreg  <= '0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         bitidx <= bitidx_n;
         shreg  <= shreg_n;
      end
   end

   assign sample = (cnt == 16'd0);

   // Half-period load on the start edge centres all later samples in their bit cells.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt - 16'd1;
      bitidx_n  = bitidx;
      shreg_n   = shreg;
      push      = 1'b0;
      frame_set = 1'b0;
      par_set   = 1'b0;
      case (state)
         IDLE: begin
            if (rx_prev && !rx_s) begin
               cnt_n   = {1'b0, i_scaler[15:1]};
               state_n = START;
            end
         end
         START: begin
            if (sample) begin
               cnt_n = i_scaler;
               if (rx_s) begin
                  state_n = IDLE;
               end else begin
                  state_n  = DATA;
                  bitidx_n = 3'd0;
               end
            end
         end
         DATA: begin
            if (sample) begin
               cnt_n    = i_scaler;
               shreg_n  = {rx_s, shreg[7:1]};
               bitidx_n = bitidx + 3'd1;
               if (bitidx == 3'd7) begin
`ifdef ACCEL_UART_RX_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
               end
            end
         end
`ifdef ACCEL_UART_RX_PARITY_EN
         PARITY: begin
            if (sample) begin
               cnt_n   = i_scaler;
               par_set = (rx_s != ((^shreg) ^ i_parity_odd));
               state_n = STOP;
            end
         end
`endif
         STOP: begin
            if (sample) begin
               cnt_n     = i_scaler;
               state_n   = IDLE;
               push      = rx_s;
               frame_set = !rx_s;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   assign pop     = o_rvalid & i_rready;
   assign push_ok = push & ((level != DEPTH) | pop);
   assign ovf_set = push & ~push_ok;

   always_ff @(posedge i_clk) begin
      if (push_ok) mem[wr_ptr] <= shreg;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_err_frame    <= 1'b0;
         o_err_overflow <= 1'b0;
      end else begin
         o_err_frame    <= frame_set | (o_err_frame & ~i_err_clr);
         o_err_overflow <= ovf_set | (o_err_overflow & ~i_err_clr);
      end
   end

`ifdef ACCEL_UART_RX_PARITY_EN
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) o_err_parity <= 1'b0;
      else       o_err_parity <= par_set | (o_err_parity & ~i_err_clr);
   end
`else
   logic unused_par;
   assign unused_par = par_set;
`endif

   assign o_level  = level;
   assign o_rvalid = (level != '0);
   assign o_full   = (level == DEPTH);
   assign o_rdata  = o_rvalid ? mem[rd_ptr] : 8'h00;
   assign o_irq    = (i_irq_thresh != '0) && (level >= i_irq_thresh);

endmodule

// File: tb/tb_accel_uart_rx.sv
// Randomised bench for accel_uart_rx against a queue-based model of the received byte stream.
// Parity checks are included when ACCEL_UART_RX_PARITY_EN is defined.
module tb_accel_uart_rx;
   localparam int L = 4;
   localparam int D = 1 << L;

   logic         clk = 1'b0;
   logic         rst;
   logic [15:0]  scaler;
   logic [L:0]   irq_thresh;
   logic         err_clr;
   logic         rx;
   logic [7:0]   rdata;
   logic         rvalid;
   logic         rready;
   logic [L:0]   level;
   logic         full, err_frame, err_overflow, irq;
`ifdef ACCEL_UART_RX_PARITY_EN
   logic         parity_odd;
   logic         err_parity;
`endif

   accel_uart_rx #(.log2_fifosz(L)) dut (
      .i_clk(clk), .i_rst(rst), .i_scaler(scaler), .i_irq_thresh(irq_thresh),
      .i_err_clr(err_clr), .i_rx(rx), .o_rdata(rdata), .o_rvalid(rvalid),
      .i_rready(rready), .o_level(level), .o_full(full), .o_err_frame(err_frame),
      .o_err_overflow(err_overflow), .o_irq(irq)
`ifdef ACCEL_UART_RX_PARITY_EN
      , .i_parity_odd(parity_odd), .o_err_parity(err_parity)
`endif
   );

   always #5 clk = ~clk;

   // reference model: byte queue plus sticky flags
   byte unsigned q[$];
   bit  m_frm, m_ovf, m_par;
   int  checks = 0, errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_state(input string tag);
      int n;
      n = q.size();
      chk({tag, ".level"},  32'(level),  32'(n));
      chk({tag, ".rvalid"}, 32'(rvalid), 32'(n != 0));
      chk({tag, ".full"},   32'(full),   32'(n == D));
      chk({tag, ".frm"},    32'(err_frame),    32'(m_frm));
      chk({tag, ".ovf"},    32'(err_overflow), 32'(m_ovf));
      chk({tag, ".irq"},    32'(irq), 32'((irq_thresh != 0) && (n >= int'(irq_thresh))));
      if (n != 0) chk({tag, ".rdata"}, 32'(rdata), 32'(q[0]));
`ifdef ACCEL_UART_RX_PARITY_EN
      chk({tag, ".par"},    32'(err_parity), 32'(m_par));
`endif
   endtask

   task automatic send_bit(input logic b, input int s);
      rx = b;
      repeat (s + 1) @(negedge clk);
   endtask

   // One full frame; stop=0 forces a framing error, pflip corrupts the parity bit.
   task automatic send_frame(input byte unsigned d, input logic stop, input int s, input bit pflip);
      scaler = 16'(s);
      send_bit(1'b0, s);
      for (int i = 0; i < 8; i++) send_bit(d[i], s);
`ifdef ACCEL_UART_RX_PARITY_EN
      send_bit((^d) ^ parity_odd ^ pflip, s);
      if (pflip) m_par = 1'b1;
`endif
      send_bit(stop, s);
      rx = 1'b1;
      repeat (3) @(negedge clk);
      if (!stop)             m_frm = 1'b1;
      else if (q.size() < D) q.push_back(d);
      else                   m_ovf = 1'b1;
   endtask

   task automatic pop_n(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         if (q.size() == 0) break;
         chk({tag, ".head"}, 32'(rdata), 32'(q[0]));
         rready = 1'b1;
         @(negedge clk);
         rready = 1'b0;
         void'(q.pop_front());
      end
      check_state(tag);
   endtask

   task automatic clr_err();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      m_frm = 0; m_ovf = 0; m_par = 0;
   endtask

   initial begin
      rst = 1'b1; rx = 1'b1; scaler = 16'd15; irq_thresh = '0; err_clr = 1'b0; rready = 1'b0;
`ifdef ACCEL_UART_RX_PARITY_EN
      parity_odd = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("rst.rvalid", 32'(rvalid), 0);
      chk("rst.level",  32'(level), 0);
      chk("rst.rdata",  32'(rdata), 0);
      chk("rst.flags",  32'({full, err_frame, err_overflow, irq}), 0);
      rst = 1'b0;
      @(negedge clk);

      // single byte
      send_frame(8'hA5, 1'b1, 15, 1'b0);
      check_state("t1");

      // fill, overflow, drain in order
      pop_n(D, "t2pre");
      for (int i = 1; i <= D; i++) send_frame(byte'(i), 1'b1, 15, 1'b0);
      check_state("t2full");
      send_frame(8'h11, 1'b1, 15, 1'b0);
      check_state("t2ovf");
      pop_n(D, "t2drain");
      clr_err();
      check_state("t2clr");

      // irq threshold
      irq_thresh = 5'd3;
      for (int i = 0; i < 3; i++) begin
         send_frame(byte'(8'h20 + i), 1'b1, 15, 1'b0);
         check_state("t3push");
      end
      pop_n(1, "t3pop");
      irq_thresh = '0;
      check_state("t3off");
      pop_n(D, "t3drain");

      // framing error, clear, recovery
      send_frame(8'h55, 1'b0, 15, 1'b0);
      check_state("t4frm");
      clr_err();
      check_state("t4clr");
      send_frame(8'h3C, 1'b1, 15, 1'b0);
      check_state("t4ok");
      pop_n(1, "t4pop");

      // short low glitch is rejected at the start sample
      scaler = 16'd15;
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (24) @(negedge clk);
      check_state("t5glitch");

      // reset in the middle of bit 4 with two bytes queued
      send_frame(8'h01, 1'b1, 15, 1'b0);
      send_frame(8'h02, 1'b1, 15, 1'b0);
      check_state("t6pre");
      send_bit(1'b0, 15);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 15);
      rx = 1'b0;
      repeat (8) @(negedge clk);
      rst = 1'b1;
      rx = 1'b1;
      q.delete(); m_frm = 0; m_ovf = 0; m_par = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check_state("t6rst");
      send_frame(8'h7E, 1'b1, 15, 1'b0);
      check_state("t6after");
      pop_n(1, "t6pop");

`ifdef ACCEL_UART_RX_PARITY_EN
      parity_odd = 1'b0;
      send_frame(8'h07, 1'b1, 15, 1'b1);
      check_state("tpar");
      clr_err();
      parity_odd = 1'b1;
      send_frame(8'hC3, 1'b1, 15, 1'b0);
      check_state("tpar_odd");
      pop_n(D, "tpar_drain");
`endif

      // randomised traffic
      for (int it = 0; it < 30; it++) begin
         byte unsigned d;
         int s;
         d = byte'($urandom);
         s = int'($urandom_range(7, 31));
         irq_thresh = 5'($urandom_range(0, 6));
`ifdef ACCEL_UART_RX_PARITY_EN
         parity_odd = 1'($urandom);
         send_frame(d, ($urandom_range(0, 9) != 0), s, ($urandom_range(0, 5) == 0));
`else
         send_frame(d, ($urandom_range(0, 9) != 0), s, 1'b0);
`endif
         check_state("rnd");
         if ($urandom_range(0, 2) == 0) pop_n(int'($urandom_range(1, 3)), "rndpop");
         if ($urandom_range(0, 4) == 0) begin
            clr_err();
            check_state("rndclr");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
